// File: rtl/ram_ctrl_pkg.sv
// Shared sizing and grant encoding for the capture-RAM arbiter.
package ram_ctrl_pkg;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 8;
  localparam logic [ADDR_W-1:0] START_ADDR = '1;

  typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_RD} grant_e;

endpackage

// File: rtl/wr_ptr_counter.sv
// Descending write pointer for the capture RAM; reloads START_ADDR after address 0.
module wr_ptr_counter #(
  parameter int unsigned       ADDR_W     = ram_ctrl_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] START_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              dec,
  output logic [ADDR_W-1:0] ptr,
  output logic              wrap_pulse
);

  logic [ADDR_W-1:0] r_ptr;

  assign wrap_pulse = dec && (r_ptr == '0);
  assign ptr        = r_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= START_ADDR;
    end else if (clear) begin
      r_ptr <= START_ADDR;
    end else if (dec) begin
      r_ptr <= wrap_pulse ? START_ADDR : r_ptr - ADDR_W'(1);
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing a single-port capture RAM between a descending-address
// writer and a host reader, with fill-level and wrap tracking.
module ram_arbiter #(
  parameter int unsigned       ADDR_W     = ram_ctrl_pkg::ADDR_W,
  parameter int unsigned       DATA_W     = ram_ctrl_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] START_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              ram_ena,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              wrapped,
  output logic [ADDR_W:0]   fill_count
);

  import ram_ctrl_pkg::*;

  localparam logic [ADDR_W:0] FillMax = {1'b1, {ADDR_W{1'b0}}};

  grant_e            w_grant;
  grant_e            r_last_gnt;
  logic [ADDR_W-1:0] w_ptr;
  logic              w_wrap;
  logic              r_ram_ena;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_rd_pend;
  logic              r_rd_valid;
  logic [ADDR_W:0]   r_fill;
  logic              r_wrapped;

  always_comb begin
    w_grant = GNT_NONE;
    if (!clear) begin
      if (wr_req && rd_req) begin
        w_grant = (r_last_gnt == GNT_WR) ? GNT_RD : GNT_WR;
      end else if (wr_req) begin
        w_grant = GNT_WR;
      end else if (rd_req) begin
        w_grant = GNT_RD;
      end
    end
  end

  assign wr_ack = (w_grant == GNT_WR);
  assign rd_ack = (w_grant == GNT_RD);

  wr_ptr_counter #(
    .ADDR_W     (ADDR_W),
    .START_ADDR (START_ADDR)
  ) u_wr_ptr_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .dec        (wr_ack),
    .ptr        (w_ptr),
    .wrap_pulse (w_wrap)
  );

  // Reset to GNT_RD so the writer wins the first contention.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_gnt <= GNT_RD;
    end else if (w_grant != GNT_NONE) begin
      r_last_gnt <= w_grant;
    end
  end

  // Address and data hold their last values on idle cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ram_ena   <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_ram_ena <= (w_grant != GNT_NONE);
      r_ram_we  <= (w_grant == GNT_WR);
      if (w_grant == GNT_WR) begin
        r_ram_addr  <= w_ptr;
        r_ram_wdata <= wr_data;
      end else if (w_grant == GNT_RD) begin
        r_ram_addr  <= rd_addr;
      end
    end
  end

  // Two stages: RAM access cycle, then the cycle ram_rdata is valid. Clear does not cancel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_pend  <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_pend  <= (w_grant == GNT_RD);
      r_rd_valid <= r_rd_pend;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fill    <= '0;
      r_wrapped <= 1'b0;
    end else if (clear) begin
      r_fill    <= '0;
      r_wrapped <= 1'b0;
    end else begin
      if (wr_ack && (r_fill != FillMax)) begin
        r_fill <= r_fill + (ADDR_W + 1)'(1);
      end
      if (w_wrap) begin
        r_wrapped <= 1'b1;
      end
    end
  end

  assign ram_ena    = r_ram_ena;
  assign ram_we     = r_ram_we;
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;
  assign rd_valid   = r_rd_valid;
  assign rd_data    = ram_rdata;
  assign fill_count = r_fill;
  assign wrapped    = r_wrapped;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer for the single-port 2048x8 capture RAM. It shares the RAM between a capture writer and a host reader, one access per cycle. Writes land at a self-managed descending address pointer (0x7FF down to 0x000, then wrap). The block also tracks fill level and wrap status for the readout logic.

## Interface
Parameters:
- ADDR_W, 11, RAM address width
- DATA_W, 8, RAM data width
- START_ADDR, 2**ADDR_W-1 (0x7FF), first write address and wrap target

Ports:
- clk  in  1  system clock, all logic rising-edge
- reset_n  in  1  reset, asynchronous and active-low
- clear  in  1  synchronous restart of pointer and status
- wr_req  in  1  writer holds a byte
- wr_data  in  DATA_W  byte to write
- wr_ack  out  1  write accepted this cycle (combinational)
- rd_req  in  1  reader requests a read
- rd_addr  in  ADDR_W  read address
- rd_ack  out  1  read accepted this cycle (combinational)
- rd_valid  out  1  rd_data valid
- rd_data  out  DATA_W  read result
- ram_ena  out  1  RAM enable, registered
- ram_we  out  1  RAM write enable, registered
- ram_addr  out  ADDR_W  RAM address, registered
- ram_wdata  out  DATA_W  RAM write data, registered
- ram_rdata  in  DATA_W  RAM read data, 1-cycle synchronous latency
- wrapped  out  1  sticky; pointer has wrapped at least once
- fill_count  out  ADDR_W+1  valid entries, saturates at 2**ADDR_W

## Operation
- Reset values:
  - wr_ptr=START_ADDR, fill_count=0, wrapped=0
  - ram_ena=0, ram_we=0, ram_addr=0, ram_wdata=0, rd_valid=0
  - last_gnt=GNT_RD, so the writer wins the first contention.
- Grant per cycle, evaluated in priority order:
  - clear=1: no ack is issued.
  - Only one request: that request is granted.
  - Both requests: grant the side opposite last_gnt (round-robin).
  - Neither request: GNT_NONE. last_gnt is unchanged.
- last_gnt updates only on an actual grant.
- Accepted write:
  - Registers ram_we=1, ram_addr=wr_ptr, ram_wdata=wr_data.
  - wr_ptr then decrements. When wr_ptr=0, it reloads START_ADDR and wrapped sets.
  - fill_count increments unless it is already 2**ADDR_W. At full, the oldest data is overwritten with no stall.
- Accepted read:
  - Registers ram_we=0, ram_addr=rd_addr.
  - Returns data through the read pipeline.
  - No range check: reads of unwritten addresses return RAM contents as-is.
- clear=1:
  - wr_ptr=START_ADDR, fill_count=0, wrapped=0. last_gnt is unchanged.
  - An in-flight read still completes.
- Requesters hold req and data stable until ack. Dropping req before ack is legal and loses nothing.

## Timing
- Cycle N: req and ack high.
- Cycle N+1: ram_* signals driven, with ram_ena=1 for exactly one cycle.
- Cycle N+2 (reads only): rd_valid=1 and rd_data=ram_rdata (combinational pass-through). rd_valid is a 1-cycle pulse.
- Throughput is one access per cycle. Back-to-back reads give back-to-back rd_valid.
- With no grant in cycle N, ram_ena=0 and ram_we=0 in N+1. ram_addr and ram_wdata hold their previous values.
- fill_count, wrapped and wr_ptr update at the end of cycle N, visible in N+1.
- If a write is accepted in the same cycle as a wrap, wrapped is visible in N+1. If clear is also high, no write is accepted that cycle.
- reset_n low mid-access: all outputs go to reset values immediately; the pending rd_valid is dropped.

## Structure
- Package ram_ctrl_pkg contains:
  - ADDR_W, DATA_W, START_ADDR
  - typedef enum logic [1:0] grant_e {GNT_NONE, GNT_WR, GNT_RD}
- Sub-module wr_ptr_counter:
  - Inputs: clk, reset_n, clear, dec.
  - Outputs: ptr, wrap_pulse.
  - Holds the descending pointer and wrap logic.
- Top level contains:
  - grant logic and the last_gnt register
  - RAM output registers
  - rd_valid pipeline flop
  - fill_count and wrapped registers

## Test plan
- Write-only sequence:
  - Stimulus: after reset, 3 writes 0xA1, 0xA2, 0xA3.
  - Response: ram_addr 0x7FF, 0x7FE, 0x7FD with ram_we=1; fill_count=3; wrapped=0.
- Contention:
  - Stimulus: wr_req and rd_req held high together for 4 cycles.
  - Response: grants WR, RD, WR, RD. rd_valid arrives 2 cycles after each rd_ack.
- Read latency:
  - Stimulus: write 0x5C to 0x7FF, then read rd_addr=0x7FF.
  - Response: rd_valid=1 with rd_data=0x5C exactly 2 cycles after rd_ack.
- Wrap:
  - Stimulus: 2048 writes, then 1 more write.
  - Response: write 2048 goes to 0x000; write 2049 goes to 0x7FF; wrapped=1; fill_count stays 2048.
- Clear during contention:
  - Stimulus: clear=1 while both requests are high.
  - Response: no ack; next write goes to 0x7FF; fill_count=1.
- Reset mid-read:
  - Stimulus: reset_n low in cycle N+1 of a read.
  - Response: no rd_valid; all outputs at reset values.
